// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: one shared edge/center-aligned period counter feeding NUM_CH compare
// channels, with period/mode/duty double-buffered and applied only at period starts.
module pwm_multichannel #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        period_in,
  input  logic                    mode_in,
  input  logic                    period_wr,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic [NUM_CH-1:0]       duty_wr,
  input  logic [NUM_CH-1:0]       polarity,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_start,
  output logic                    update_pending
);

  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic [CNT_W-1:0] per_pend_q, per_act_q;
  mode_e            mode_pend_q, mode_act_q;
  logic [CNT_W-1:0] duty_pend_q [NUM_CH];
  logic [CNT_W-1:0] duty_act_q  [NUM_CH];
  logic             per_flag_q;
  logic [NUM_CH-1:0] duty_flag_q;
  logic [NUM_CH-1:0] pwm_d;
  logic             run, last, transfer;

  always_comb begin
    run  = enable && (per_act_q >= TWO);
    last = 1'b0;
    if (mode_act_q == MODE_EDGE) begin
      last = (cnt_q == per_act_q - ONE);
    end else begin
      // With P=2 the up-count peak is also the step back to the trough.
      last = ((dir_q == DIR_DOWN) && (cnt_q == ONE)) ||
             ((dir_q == DIR_UP) && (cnt_q == per_act_q - ONE) && (per_act_q == TWO));
    end
    // Idle or degenerate periods hold the counter at 0 and keep loading pending values.
    transfer = !run || last;

    cnt_d = cnt_q;
    dir_d = dir_q;
    if (transfer) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act_q == MODE_EDGE) begin
      cnt_d = cnt_q + ONE;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == per_act_q - ONE) begin
        cnt_d = cnt_q - ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q - ONE;
    end

    pwm_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (run && (cnt_q < duty_act_q[i])) ^ polarity[i];
    end
  end

  assign update_pending = per_flag_q | (|duty_flag_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      per_pend_q   <= '0;
      per_act_q    <= '0;
      mode_pend_q  <= MODE_EDGE;
      mode_act_q   <= MODE_EDGE;
      per_flag_q   <= 1'b0;
      duty_flag_q  <= '0;
      pwm_out      <= '0;
      period_start <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_pend_q[i] <= '0;
        duty_act_q[i]  <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pwm_out      <= pwm_d;
      period_start <= run && (cnt_q == '0);

      if (transfer) begin
        per_act_q  <= per_pend_q;
        mode_act_q <= mode_pend_q;
      end
      if (period_wr) begin
        per_pend_q  <= period_in;
        mode_pend_q <= mode_e'(mode_in);
        per_flag_q  <= 1'b1;
      end else if (transfer) begin
        per_flag_q  <= 1'b0;
      end

      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (transfer) begin
          duty_act_q[i] <= duty_pend_q[i];
        end
        if (duty_wr[i]) begin
          duty_pend_q[i] <= duty_in[i*CNT_W +: CNT_W];
          duty_flag_q[i] <= 1'b1;
        end else if (transfer) begin
          duty_flag_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel: expected {pwm_out, period_start, update_pending}
// per cycle are queued from closed-form waveforms and compared as the DUT runs.
module tb_pwm_multichannel;

  typedef struct packed {
    logic [3:0] pwm;
    logic       ps;
    logic       up;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, enable, mode_in, period_wr;
  logic [15:0] period_in;
  logic [63:0] duty_in;
  logic [3:0]  duty_wr, polarity;
  logic [3:0]  pwm_out;
  logic        period_start, update_pending;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  pwm_multichannel #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period_in(period_in),
    .mode_in(mode_in), .period_wr(period_wr), .duty_in(duty_in), .duty_wr(duty_wr),
    .polarity(polarity), .pwm_out(pwm_out), .period_start(period_start),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle, load new period/mode/duty, then let one idle edge transfer them.
  task automatic cfg(input logic [15:0] p, input logic m, input logic [63:0] d);
    enable    = 1'b0;
    period_in = p;
    mode_in   = m;
    period_wr = 1'b1;
    duty_in   = d;
    duty_wr   = 4'b1111;
    step();
    period_wr = 1'b0;
    duty_wr   = 4'b0000;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; period_wr = 1'b0; duty_wr = '0;
    period_in = '0; mode_in = 1'b0; duty_in = '0; polarity = 4'b1111;
    step(); step();
    total++;
    if ({pwm_out, period_start, update_pending} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {pwm_out, period_start, update_pending}, 6'b0);
    end
    reset = 1'b0;
    step();
    total++;
    if ({pwm_out, period_start, update_pending} !== {4'b1111, 2'b00}) begin
      bad++;
      $display("FAIL idle_polarity got=%b exp=%b", {pwm_out, period_start, update_pending}, {4'b1111, 2'b00});
    end
    polarity = 4'b0000;
  endtask

  task automatic test_edge();
    cfg(16'd10, 1'b0, {16'd0, 16'd0, 16'd0, 16'd3});
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      e.pwm = {3'b000, (k % 10) < 3};
      e.ps  = (k % 10) == 0;
      e.up  = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 30; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL edge k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
    end
  endtask

  task automatic test_center();
    int seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    cfg(16'd5, 1'b1, {16'd0, 16'd0, 16'd0, 16'd2});
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      e.pwm = {3'b000, seq[k % 8] < 2};
      e.ps  = (k % 8) == 0;
      e.up  = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL center k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
    end
  endtask

  task automatic test_double_buffer();
    int d;
    cfg(16'd10, 1'b0, {16'd0, 16'd0, 16'd0, 16'd3});
    enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d = (k < 10) ? 3 : (k < 30) ? 7 : 2;
      e.pwm = {3'b000, (k % 10) < d};
      e.ps  = (k % 10) == 0;
      e.up  = (k >= 5 && k < 9) || (k >= 19 && k < 29);
      sb.push_back(e);
    end
    for (int k = 0; k < 40; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL dbuf k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
      // Write at counter=5 mid-period, then one that lands on the transfer edge.
      if (k == 4 || k == 18) begin
        duty_in[15:0] = (k == 4) ? 16'd7 : 16'd2;
        duty_wr       = 4'b0001;
      end else begin
        duty_wr = 4'b0000;
      end
    end
  endtask

  task automatic test_bounds_polarity();
    logic h;
    polarity = 4'b0010;
    cfg(16'd10, 1'b0, {16'd12, 16'd0, 16'd3, 16'd3});
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      h = (k % 10) < 3;
      e.pwm = {1'b1, 1'b0, ~h, h};
      e.ps  = (k % 10) == 0;
      e.up  = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL bounds k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
    end
    cfg(16'd1, 1'b0, {16'd12, 16'd0, 16'd3, 16'd3});
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      e.pwm = 4'b0010; e.ps = 1'b0; e.up = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL p1 k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
    end
  endtask

  task automatic test_enable_reset();
    logic h;
    int   j;
    cfg(16'd10, 1'b0, {16'd12, 16'd0, 16'd3, 16'd3});
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 6 || k == 7) begin
        e.pwm = 4'b0010; e.ps = 1'b0;
      end else begin
        j = (k < 6) ? k : k - 8;
        h = (j % 10) < 3;
        e.pwm = {1'b1, 1'b0, ~h, h};
        e.ps  = (j % 10) == 0;
      end
      e.up = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL enable k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
      if (k == 5) enable = 1'b0;
      if (k == 7) enable = 1'b1;
    end
    period_in = 16'd4; period_wr = 1'b1;
    duty_in[15:0] = 16'd5; duty_wr = 4'b0001;
    step();
    period_wr = 1'b0; duty_wr = 4'b0000;
    total++;
    if (update_pending !== 1'b1) begin
      bad++;
      $display("FAIL pend_before_reset got=%b exp=%b", update_pending, 1'b1);
    end
    reset = 1'b1;
    step();
    total++;
    if ({pwm_out, period_start, update_pending} !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=%b", {pwm_out, period_start, update_pending}, 6'b0);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      e.pwm = 4'b0010; e.ps = 1'b0; e.up = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      e = sb.pop_front();
      total++;
      if ({pwm_out, period_start, update_pending} !== e) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%b exp=%b", k, {pwm_out, period_start, update_pending}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_double_buffer();
    test_bounds_polarity();
    test_enable_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
- Multi-channel PWM generator: one shared period counter drives NUM_CH compare channels.
- Supports edge-aligned and center-aligned modes and per-channel output polarity.
- Period, mode and duty writes are double-buffered; they take effect only at a period start, so no glitched or truncated pulse is ever produced.
- Sits between the control/register logic and the motor/LED driver pins.
- Successor to the single-channel fixed-frequency-table PWM.

Parameters:
- NUM_CH, 4, number of PWM output channels.
- CNT_W, 16, width of counter, period and duty values (period count in clk cycles).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run counter; low = idle, outputs at inactive level.
- period_in  input  CNT_W  new period P, in clk cycles.
- mode_in  input  1  new mode: 0 edge-aligned, 1 center-aligned.
- period_wr  input  1  one-cycle strobe; captures period_in and mode_in into pending registers.
- duty_in  input  NUM_CH*CNT_W  per-channel compare values; channel i occupies bits [i*CNT_W +: CNT_W].
- duty_wr  input  NUM_CH  per-channel strobe; captures that channel's slice into its pending register.
- polarity  input  NUM_CH  1 = channel output inverted. Not buffered; applies immediately.
- pwm_out  output  NUM_CH  registered PWM outputs.
- period_start  output  1  registered; high in the cycle aligned with the first pwm_out sample of each period.
- update_pending  output  1  high while any pending value is not yet transferred to active.

Behaviour:
- Reset: counter=0, dir=up, pending and active period/mode/duty=0, all pending flags clear, pwm_out=0, period_start=0, update_pending=0.
- Writes: a strobe loads the pending register and sets that register's pending flag. update_pending = OR of all flags.
- Transfer (pending -> active):
  - Occurs on the clock edge at which the counter is loaded with 0 at a period start.
  - Also occurs on every edge while enable=0.
  - Transfer takes the pending value present before that edge.
  - A strobe on the same edge lands in pending, keeps its flag set, and applies at the next transfer.
- Degenerate period: active P<2 means the counter is held at 0 and all channels output the inactive level.
- Edge mode:
  - Counter runs 0,1,…,P-1, then 0. Period = P cycles.
  - raw_i = (counter < duty_i).
- Center mode:
  - Counter counts up from 0 to P-1, then down from P-2 to 0, then up again. Period = 2(P-1) cycles; the period start is the trough (counter=0).
  - raw_i = (counter < duty_i).
  - High time = 2*duty_i-1 cycles for 1<=duty_i<=P-1.
- Duty bounds (both modes):
  - duty_i=0 -> raw always 0.
  - duty_i>=P -> raw always 1.
- Output:
  - pwm_out[i] <= raw_i XOR polarity[i]. Latency is 1 cycle from the counter value.
  - The inactive level is polarity[i].
- period_start:
  - Registered from (enable && counter==0 && P>=2).
  - Exactly one cycle per period.
  - Also high in the first cycle after enable rises.
- enable=0 handling:
  - Counter forced to 0, dir forced up.
  - From the next edge, pwm_out = polarity and period_start = 0.
  - Pending values transfer continuously.
- enable rising: the counter leaves 0 on the following edge. The first period uses the active values loaded while idle.
- Mode change applies only at a transfer, and dir restarts up.
- Reset mid-operation: all state returns to reset values on the next edge; pending writes are discarded.
- Arithmetic: the counter and all compares are unsigned CNT_W-bit. There is no wrap beyond P-1, because the terminal count is compared with the active period.

Test Plan:
1. Edge mode basic: reset, write P=10, mode 0, duty0=3, enable=1 -> pwm_out[0] repeats 3 high / 7 low; period_start pulses every 10 cycles, aligned with the first high cycle.
2. Center mode: P=5, mode 1, duty0=2, enable -> counter sequence 0,1,2,3,4,3,2,1 (8-cycle period); pwm_out[0] high for 3 cycles centred on the trough.
3. Double buffering:
   - While running P=10 / duty=3, write duty0=7 at counter=5 -> the current period completes with 3 high cycles and update_pending=1.
   - The next period has 7 high cycles and update_pending drops at that transfer.
   - A write landing on the transfer edge is deferred one full period.
4. Bounds and polarity:
   - duty=0 -> constantly 0.
   - duty=12 with P=10 -> constantly 1.
   - polarity[1]=1 with duty1=3 -> channel 1 is the complement of channel 0.
   - P=1 -> all outputs at inactive level and period_start never asserts.
5. Enable/reset mid-period:
   - Drop enable at counter=6 -> next cycle pwm_out=polarity and the counter is 0.
   - Re-enable -> a full fresh period.
   - Assert reset mid-period -> pwm_out=0 and pending writes are lost; after reset, P=0 keeps outputs inactive.
